// File: rtl/riscv_core_div_pkg.sv
// Shared encodings for the RV64M divide controller: operation codes and FSM states.
package riscv_core_div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] DIV_OP_DIVW  = DIV_OP_DIV;
  localparam logic [1:0] DIV_OP_DIVUW = DIV_OP_DIVU;
  localparam logic [1:0] DIV_OP_REMW  = DIV_OP_REM;
  localparam logic [1:0] DIV_OP_REMUW = DIV_OP_REMU;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic div_op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/riscv_core_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; no handshake.
module riscv_core_div_step
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem,
  input  logic            quo_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic            quo_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem[XLEN-1:0], quo_msb};
  assign diff    = shifted - {1'b0, divisor};
  // rem[XLEN] stays clear while rem < divisor; if ever set it acts as the carry into the compare
  assign quo_bit  = rem[XLEN] | (shifted >= {1'b0, divisor});
  assign rem_next = quo_bit ? diff : shifted;

endmodule

// File: rtl/riscv_core_div_ctrl.sv
// Iterative RV64M divide sequencer: XLEN (or XLEN/2 for W ops) cycles per result, 1 for div-by-zero.
// Single request in flight; result held in DONE until the consumer takes it.
module riscv_core_div_ctrl
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_ctrl_valid,
  output logic            o_div_ctrl_ready,
  input  logic [XLEN-1:0] i_div_ctrl_srcA,
  input  logic [XLEN-1:0] i_div_ctrl_srcB,
  input  logic [1:0]      i_div_ctrl_control,
  input  logic            i_div_ctrl_isword,
  input  logic            i_div_ctrl_flush,
  output logic            o_div_ctrl_valid,
  input  logic            i_div_ctrl_out_ready,
  output logic [XLEN-1:0] o_div_ctrl_quotient,
  output logic [XLEN-1:0] o_div_ctrl_remainder,
  output logic            o_div_ctrl_srcA_Dsign,
  output logic            o_div_ctrl_srcB_Dsign,
  output logic            o_div_ctrl_srcA_Wsign,
  output logic            o_div_ctrl_srcB_Wsign,
  output logic [1:0]      o_div_ctrl_control,
  output logic            o_div_ctrl_isword
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  div_state_e state, state_nxt;

  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [CW-1:0]   cnt_q;
  logic            a_dsign_q, b_dsign_q, a_wsign_q, b_wsign_q;
  logic [1:0]      ctrl_q;
  logic            isword_q;

  logic            is_signed;
  logic            a_dsign, b_dsign, a_wsign, b_wsign;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, quo_init;
  logic [CW-1:0]   cnt_init;
  logic            b_zero;
  logic            accept;
  logic [XLEN:0]   step_rem;
  logic            step_bit;

  assign is_signed = div_op_is_signed(i_div_ctrl_control);
  assign a_dsign   = is_signed & i_div_ctrl_srcA[XLEN-1];
  assign b_dsign   = is_signed & i_div_ctrl_srcB[XLEN-1];
  assign a_wsign   = is_signed & i_div_ctrl_srcA[HALF-1];
  assign b_wsign   = is_signed & i_div_ctrl_srcB[HALF-1];
  assign a_neg     = i_div_ctrl_isword ? a_wsign : a_dsign;
  assign b_neg     = i_div_ctrl_isword ? b_wsign : b_dsign;

  assign a_ext = i_div_ctrl_isword ? {{HALF{a_wsign}}, i_div_ctrl_srcA[HALF-1:0]} : i_div_ctrl_srcA;
  assign b_ext = i_div_ctrl_isword ? {{HALF{b_wsign}}, i_div_ctrl_srcB[HALF-1:0]} : i_div_ctrl_srcB;
  assign a_mag = a_neg ? (~a_ext + ONE) : a_ext;
  assign b_mag = b_neg ? (~b_ext + ONE) : b_ext;

  // Word dividends sit in the top half so the quotient lands in the low half after HALF steps
  assign quo_init = i_div_ctrl_isword ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
  assign cnt_init = i_div_ctrl_isword ? CW'(HALF - 1) : CW'(XLEN - 1);
  assign b_zero   = (b_ext == '0);
  assign accept   = (state == IDLE) & i_div_ctrl_valid & ~i_div_ctrl_flush;

  riscv_core_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo_msb  (quo_q[XLEN-1]),
    .divisor  (div_q),
    .rem_next (step_rem),
    .quo_bit  (step_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    if (i_div_ctrl_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_div_ctrl_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      a_dsign_q <= 1'b0;
      b_dsign_q <= 1'b0;
      a_wsign_q <= 1'b0;
      b_wsign_q <= 1'b0;
      ctrl_q    <= '0;
      isword_q  <= 1'b0;
    end else if (accept) begin
      ctrl_q   <= i_div_ctrl_control;
      isword_q <= i_div_ctrl_isword;
      div_q    <= b_mag;
      if (b_zero) begin
        // Zeroed sign flags make sign correction return -1 and the dividend untouched
        quo_q     <= '1;
        rem_q     <= {1'b0, a_ext};
        cnt_q     <= '0;
        a_dsign_q <= 1'b0;
        b_dsign_q <= 1'b0;
        a_wsign_q <= 1'b0;
        b_wsign_q <= 1'b0;
      end else begin
        quo_q     <= quo_init;
        rem_q     <= '0;
        cnt_q     <= cnt_init;
        a_dsign_q <= a_dsign;
        b_dsign_q <= b_dsign;
        a_wsign_q <= a_wsign;
        b_wsign_q <= b_wsign;
      end
    end else if (state == CALC) begin
      rem_q <= step_rem;
      quo_q <= {quo_q[XLEN-2:0], step_bit};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign o_div_ctrl_ready      = (state == IDLE);
  assign o_div_ctrl_valid      = (state == DONE);
  assign o_div_ctrl_quotient   = quo_q;
  assign o_div_ctrl_remainder  = rem_q[XLEN-1:0];
  assign o_div_ctrl_srcA_Dsign = a_dsign_q;
  assign o_div_ctrl_srcB_Dsign = b_dsign_q;
  assign o_div_ctrl_srcA_Wsign = a_wsign_q;
  assign o_div_ctrl_srcB_Wsign = b_wsign_q;
  assign o_div_ctrl_control    = ctrl_q;
  assign o_div_ctrl_isword     = isword_q;

endmodule
